wvb_rd_arbiter: RTL
===================

// Module: wvb_rd_arbiter
// PURPOSE
//  Parametrised channel arbiter and DPRAM hand-off sequencer for the mDOM waveform-buffer read path.
//  It scans up to 32 WVB channels and picks the next non-empty, enabled channel in one cycle (round-robin, empty channels skipped).
//  It pops that channel's header, drives an external read controller over req/ack and runs the DPRAM hand-off.
//  Also provides: per-channel enable mask, multi-event bursts per grant, a DPRAM-start watchdog and an event counter.
//  Its sel_idx output steers the WVB/header data muxes feeding the read controller.
// PARAMETERS
//  N_CHANNELS     2      number of WVB channels, 1..32
//  IDX_WIDTH      5      width of sel_idx; 2**IDX_WIDTH >= N_CHANNELS
//  HDR_WT_CNT     3      cycles from hdr_rdreq to rd_ctrl_req (header pipeline latency), >=1
//  BURST_MAX      1      max events read from one channel per grant before rotating, >=1
//  TIMEOUT_CYCLES 65535  max cycles waiting for dpram_busy to rise after dpram_run; 0 = watchdog off
//  CNT_WIDTH      16     width of evt_count
// PORTS
//  clk            in   1           system clock
//  rst            in   1           asynchronous reset, active-high
//  en             in   1           enable; low = synchronous return to S_IDLE
//  chan_mask      in   N_CHANNELS  1 = channel eligible for selection
//  hdr_empty      in   N_CHANNELS  per-channel header FIFO empty
//  hdr_rdreq      out  N_CHANNELS  one-cycle header pop, one-hot
//  sel_idx        out  IDX_WIDTH   selected channel index (mux select)
//  rd_ctrl_req    out  1           request to read controller
//  rd_ctrl_ack    in   1           read controller done with one DPRAM fill
//  rd_ctrl_more   in   1           more data remains for the next DPRAM fill
//  rd_ctrl_len    in   16          length of the fill just completed
//  dpram_len      out  16          latched rd_ctrl_len
//  dpram_run      out  1           one-cycle DPRAM start pulse
//  dpram_busy     in   1           DPRAM owned by readout
//  dpram_mode     in   1           1 = event may span several DPRAM fills
//  err_clr        in   1           clears timeout_err
//  timeout_err    out  1           sticky: watchdog fired
//  evt_count      out  CNT_WIDTH   completed events, wraps modulo 2**CNT_WIDTH
// BEHAVIOUR
//  - All outputs and internal state reset to 0: fsm=S_IDLE, rr pointer ptr=0, burst counter=0. All outputs registered.
//  - en low: fsm, ptr, burst counter and all handshake outputs go to 0 on the next clk; timeout_err and evt_count hold.
//  - Eligible set E = chan_mask & ~hdr_empty. Candidate = first set bit of E at or after ptr, cyclic over N_CHANNELS.
//  - S_IDLE: if E!=0 && !dpram_busy && !rd_ctrl_ack -> sel_idx<=candidate; hdr_rdreq[candidate]<=1 for one cycle; goto S_HDR_WAIT. Otherwise stay; ptr unchanged.
//  - S_HDR_WAIT: count HDR_WT_CNT cycles, then goto S_REQ.
//  - S_REQ: rd_ctrl_req=1 until rd_ctrl_ack. On ack: req<=0, dpram_len<=rd_ctrl_len, goto S_RUN.
//  - S_RUN: when !dpram_busy, pulse dpram_run, clear watchdog, goto S_BUSY.
//  - S_BUSY: on dpram_busy goto S_DONE.
//    Watchdog, when TIMEOUT_CYCLES>0: after TIMEOUT_CYCLES cycles without busy -> timeout_err<=1; event abandoned; ptr<=sel_idx+1 mod N; goto S_IDLE.
//  - S_DONE: wait !dpram_busy.
//    - If dpram_mode && rd_ctrl_more: when !rd_ctrl_ack, goto S_REQ. No new header pop.
//    - Else evt_count++ and burst++.
//      - If burst<BURST_MAX && E[sel_idx]: pop the same channel (hdr_rdreq) and goto S_HDR_WAIT.
//      - Else burst<=0; ptr<=sel_idx+1 mod N; goto S_IDLE.
//  - chan_mask changes affect selection only; an in-flight event on a newly masked channel completes.
//  - err_clr and watchdog firing in the same cycle: the set wins.
//  - Async rst mid-operation: outputs go to 0 without waiting for a clock edge. The in-flight event is dropped; recovery of the read controller and DPRAM is external.
//  - N_CHANNELS=1: ptr is constant 0; behaviour otherwise unchanged.
// TESTING
//  1. N=4, headers on ch0 and ch2 only, DPRAM completes immediately
//     -> grant order 0,2,0,2. hdr_rdreq appears 1 cycle after entry into S_IDLE; ch1 and ch3 cost no cycles.
//  2. BURST_MAX=2; ch1 has 3 headers, ch3 has 1 -> grant order 1,1,3,1; evt_count=4.
//  3. dpram_mode=1, rd_ctrl_more=1 for 2 fills, then 0 -> 3 req/ack cycles and 3 dpram_run pulses; exactly 1 hdr_rdreq; evt_count +1.
//  4. TIMEOUT_CYCLES=10; dpram_busy held low after dpram_run
//     -> timeout_err=1 after 10 cycles in S_BUSY; fsm returns to S_IDLE; next grant goes to the next channel.
//     Then err_clr pulse -> timeout_err=0.
//  5. chan_mask=4'b1011, headers only on ch2 -> no hdr_rdreq for 1000 cycles.
//     Then set mask bit 2 -> ch2 is granted within 2 cycles.
//  6. Assert rst in S_DONE between clock edges -> all outputs 0 immediately.
//     After release with headers pending, the first grant goes to the lowest eligible channel (ptr=0).

Source files
------------

// File: rtl/wvb_rd_arbiter.sv
// Round-robin WVB channel arbiter and DPRAM hand-off sequencer for the mDOM waveform-buffer read path.
// Pops a channel header, drives the read controller over req/ack and sequences DPRAM fills per event.
module wvb_rd_arbiter #(
    parameter int N_CHANNELS     = 2,
    parameter int IDX_WIDTH      = 5,
    parameter int HDR_WT_CNT     = 3,
    parameter int BURST_MAX      = 1,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [N_CHANNELS-1:0] chan_mask,
    input  logic [N_CHANNELS-1:0] hdr_empty,
    output logic [N_CHANNELS-1:0] hdr_rdreq,
    output logic [IDX_WIDTH-1:0]  sel_idx,
    output logic                  rd_ctrl_req,
    input  logic                  rd_ctrl_ack,
    input  logic                  rd_ctrl_more,
    input  logic [15:0]           rd_ctrl_len,
    output logic [15:0]           dpram_len,
    output logic                  dpram_run,
    input  logic                  dpram_busy,
    input  logic                  dpram_mode,
    input  logic                  err_clr,
    output logic                  timeout_err,
    output logic [CNT_WIDTH-1:0]  evt_count
);
    localparam int HW_W = $clog2(HDR_WT_CNT + 1);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 2);
    localparam int BR_W = $clog2(BURST_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR_WAIT, S_REQ, S_RUN, S_BUSY, S_DONE
    } state_t;

    state_t                state_q, state_n;
    logic [IDX_WIDTH-1:0]  ptr_q, ptr_n;
    logic [BR_W-1:0]       burst_q, burst_n;
    logic [HW_W-1:0]       hw_cnt_q, hw_cnt_n;
    logic [WD_W-1:0]       wd_cnt_q, wd_cnt_n;
    logic [N_CHANNELS-1:0] hdr_rdreq_n;
    logic [IDX_WIDTH-1:0]  sel_idx_n;
    logic                  rd_ctrl_req_n, dpram_run_n, timeout_err_n;
    logic [15:0]           dpram_len_n;
    logic [CNT_WIDTH-1:0]  evt_count_n;

    logic [N_CHANNELS-1:0] elig, cand_oh, sel_oh;
    logic [IDX_WIDTH-1:0]  cand, sel_next;
    logic                  sel_elig;

    function automatic logic [N_CHANNELS-1:0] to_onehot(input logic [IDX_WIDTH-1:0] idx);
        logic [N_CHANNELS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_CHANNELS; i++)
            if (int'(idx) == i) oh[i] = 1'b1;
        return oh;
    endfunction

    assign elig     = chan_mask & ~hdr_empty;
    assign cand_oh  = to_onehot(cand);
    assign sel_oh   = to_onehot(sel_idx);
    assign sel_elig = |(elig & sel_oh);
    assign sel_next = (int'(sel_idx) + 1 >= N_CHANNELS) ? '0 : sel_idx + 1'b1;

    // Pick the eligible channel with the smallest cyclic distance from ptr.
    always_comb begin
        int best;
        int off;
        best = N_CHANNELS;
        off  = 0;
        cand = '0;
        for (int i = 0; i < N_CHANNELS; i++) begin
            off = i - int'(ptr_q);
            if (off < 0) off = off + N_CHANNELS;
            if (elig[i] && off < best) begin
                best = off;
                cand = IDX_WIDTH'(i);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        int burst_inc;
        state_n       = state_q;
        ptr_n         = ptr_q;
        burst_n       = burst_q;
        hw_cnt_n      = hw_cnt_q;
        wd_cnt_n      = wd_cnt_q;
        hdr_rdreq_n   = '0;
        sel_idx_n     = sel_idx;
        rd_ctrl_req_n = rd_ctrl_req;
        dpram_run_n   = 1'b0;
        dpram_len_n   = dpram_len;
        evt_count_n   = evt_count;
        timeout_err_n = timeout_err & ~err_clr;
        burst_inc     = int'(burst_q) + 1;

        if (!en) begin
            state_n       = S_IDLE;
            ptr_n         = '0;
            burst_n       = '0;
            hw_cnt_n      = '0;
            wd_cnt_n      = '0;
            sel_idx_n     = '0;
            rd_ctrl_req_n = 1'b0;
            dpram_len_n   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (|elig && !dpram_busy && !rd_ctrl_ack) begin
                        sel_idx_n   = cand;
                        hdr_rdreq_n = cand_oh;
                        hw_cnt_n    = '0;
                        state_n     = S_HDR_WAIT;
                    end
                end
                S_HDR_WAIT: begin
                    if (int'(hw_cnt_q) == HDR_WT_CNT - 1) begin
                        rd_ctrl_req_n = 1'b1;
                        state_n       = S_REQ;
                    end else begin
                        hw_cnt_n = hw_cnt_q + 1'b1;
                    end
                end
                S_REQ: begin
                    if (rd_ctrl_ack) begin
                        rd_ctrl_req_n = 1'b0;
                        dpram_len_n   = rd_ctrl_len;
                        state_n       = S_RUN;
                    end
                end
                S_RUN: begin
                    if (!dpram_busy) begin
                        dpram_run_n = 1'b1;
                        wd_cnt_n    = '0;
                        state_n     = S_BUSY;
                    end
                end
                S_BUSY: begin
                    if (dpram_busy) begin
                        state_n = S_DONE;
                    end else if (TIMEOUT_CYCLES > 0) begin
                        // Readout never claimed the DPRAM: abandon the event and move on.
                        if (int'(wd_cnt_q) == TIMEOUT_CYCLES - 1) begin
                            timeout_err_n = 1'b1;
                            burst_n       = '0;
                            ptr_n         = sel_next;
                            state_n       = S_IDLE;
                        end else begin
                            wd_cnt_n = wd_cnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (!dpram_busy) begin
                        if (dpram_mode && rd_ctrl_more) begin
                            if (!rd_ctrl_ack) begin
                                rd_ctrl_req_n = 1'b1;
                                state_n       = S_REQ;
                            end
                        end else begin
                            evt_count_n = evt_count + 1'b1;
                            if (burst_inc < BURST_MAX && sel_elig) begin
                                burst_n     = BR_W'(burst_inc);
                                hdr_rdreq_n = sel_oh;
                                hw_cnt_n    = '0;
                                state_n     = S_HDR_WAIT;
                            end else begin
                                burst_n = '0;
                                ptr_n   = sel_next;
                                state_n = S_IDLE;
                            end
                        end
                    end
                end
                default: state_n = S_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            burst_q     <= '0;
            hw_cnt_q    <= '0;
            wd_cnt_q    <= '0;
            hdr_rdreq   <= '0;
            sel_idx     <= '0;
            rd_ctrl_req <= 1'b0;
            dpram_run   <= 1'b0;
            dpram_len   <= '0;
            timeout_err <= 1'b0;
            evt_count   <= '0;
        end else begin
            state_q     <= state_n;
            ptr_q       <= ptr_n;
            burst_q     <= burst_n;
            hw_cnt_q    <= hw_cnt_n;
            wd_cnt_q    <= wd_cnt_n;
            hdr_rdreq   <= hdr_rdreq_n;
            sel_idx     <= sel_idx_n;
            rd_ctrl_req <= rd_ctrl_req_n;
            dpram_run   <= dpram_run_n;
            dpram_len   <= dpram_len_n;
            timeout_err <= timeout_err_n;
            evt_count   <= evt_count_n;
        end
    end

endmodule
